// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use bubbles, redirect flushes,
// memory-wait freeze with timeout abort, and EX forwarding selects. Define HAZARD_PERF_CNT_EN for event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rs1_addr,
  input  logic [4:0]       i_ex_rs2_addr,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_redirect,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wren,
  input  logic [4:0]       i_wb_rd_addr,
  input  logic             i_wb_rd_wren,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt,
`endif
  output logic             o_mem_err
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                freeze, load_use, redirect_app, load_use_app;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (i_mem_req && !i_mem_ack) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack)                state_d = RUN;
        else if (wcnt_q == WCNT_LAST) state_d = ERR;
        else                          wcnt_d  = wcnt_q + 1'b1;
      end
      ERR:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Freeze is combinational so an ack releases the pipeline in the same cycle it arrives.
  assign freeze = !i_reset && (((state_q == RUN) && i_mem_req && !i_mem_ack) ||
                               ((state_q == MEM_WAIT) && !i_mem_ack));

  assign load_use = i_ex_is_load && (i_ex_rd_addr != 5'd0) &&
                    ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                     (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  assign redirect_app = !i_reset && !freeze && i_ex_redirect;
  assign load_use_app = !i_reset && !freeze && !i_ex_redirect && load_use;

  always_comb begin
    o_stall_if  = freeze || load_use_app;
    o_stall_id  = freeze || load_use_app;
    o_stall_ex  = freeze;
    o_stall_mem = freeze;
    o_flush_id  = redirect_app;
    o_flush_ex  = redirect_app || load_use_app;
  end

  assign o_mem_err = !i_reset && (state_q == ERR);

  // MEM result is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_mem_rd_wren && (i_mem_rd_addr != 5'd0) && (i_mem_rd_addr == rs))   return 2'b01;
    else if (i_wb_rd_wren && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == rs)) return 2'b10;
    else                                                                      return 2'b00;
  endfunction

  assign o_fwd_a_sel = i_reset ? 2'b00 : fwd_sel(i_ex_rs1_addr);
  assign o_fwd_b_sel = i_reset ? 2'b00 : fwd_sel(i_ex_rs2_addr);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (load_use_app) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_app) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (freeze)       wait_cnt_q  <= wait_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_wait_cnt  = wait_cnt_q;
`endif

endmodule
